// File: rtl/count_capture_fifo.sv
// Capture FIFO for a free-running counter: stores {wrap flag, count} samples on a
// capture strobe and presents them first-word fall-through to a valid/ready reader.
module count_capture_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             capture,
   input  logic             clr,
   output logic [WIDTH-1:0] out_data,
   output logic             out_wrap,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level,
   output logic             overflow
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH:0]   mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] prev_q;
   logic             pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic             wrap_evt, push, pop;

   assign wrap_evt  = (prev_q == '1) && (count_in == '0);
   assign full      = (level_q == DEPTH_L);
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign overflow  = ovf_q;
   assign out_valid = !empty;
   assign out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
   assign out_wrap  = mem_q[rd_ptr_q][WIDTH];
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts a capture when the head leaves in the same cycle.
   assign push      = capture && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         pend_d   = 1'b0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      level_d = level_q + 1'b1;
         else if (pop && !push) level_d = level_q - 1'b1;
         // A dropped capture leaves any wrap indication pending for the next stored sample.
         if (push)          pend_d = 1'b0;
         else if (wrap_evt) pend_d = 1'b1;
         if (capture && !push) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         prev_q   <= '0;
         pend_q   <= 1'b0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         prev_q   <= count_in;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         if (push && !clr) mem_q[wr_ptr_q] <= {pend_q | wrap_evt, count_in};
      end
   end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_count_capture_fifo;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic             CLK = 1'b1;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] count_in = '0;
   logic             capture = 1'b0;
   logic             clr = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_wrap, out_valid, full, empty, overflow;
   logic [AW:0]      level;

   int checks = 0;
   int errors = 0;

   count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .CLK(CLK), .reset(reset), .count_in(count_in), .capture(capture), .clr(clr),
      .out_data(out_data), .out_wrap(out_wrap), .out_valid(out_valid),
      .out_ready(out_ready), .full(full), .empty(empty), .level(level),
      .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   // Reference model: a queue of {wrap, count} entries.
   logic [WIDTH:0]   mq[$];
   logic [WIDTH-1:0] m_prev = '0;
   logic             m_pend = 1'b0;
   logic             m_ovf  = 1'b0;

   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_prev = '0;
         m_pend = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         bit evt, do_pop, do_push;
         evt = (m_prev == 4'hF) && (count_in == 4'h0);
         if (clr) begin
            mq.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
         end else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = capture && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               mq.push_back({m_pend | evt, count_in});
               m_pend = 1'b0;
            end else if (evt) begin
               m_pend = 1'b1;
            end
            if (capture && !do_push) m_ovf = 1'b1;
         end
         m_prev = count_in;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      int sz;
      sz = mq.size();
      chk("m_valid", int'(out_valid), int'(sz != 0));
      chk("m_empty", int'(empty), int'(sz == 0));
      chk("m_full",  int'(full),  int'(sz == DEPTH));
      chk("m_level", int'(level), sz);
      chk("m_ovf",   int'(overflow), int'(m_ovf));
      if (sz != 0) begin
         chk("m_data", int'(out_data), int'(mq[0][WIDTH-1:0]));
         chk("m_wrap", int'(out_wrap), int'(mq[0][WIDTH]));
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic push1(input int v);
      count_in = WIDTH'(v);
      capture  = 1'b1;
      cyc();
      capture  = 1'b0;
   endtask

   task automatic pop_chk(input string nm, input int d, input int w);
      chk({nm, "_valid"}, int'(out_valid), 1);
      chk({nm, "_data"},  int'(out_data), d);
      chk({nm, "_wrap"},  int'(out_wrap), w);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      #4 reset = 1'b0;

      // Reset then idle through 200 ns.
      while ($time < 200) cyc();
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_empty", int'(empty), 1);
      chk("idle_level", int'(level), 0);
      chk("idle_ovf",   int'(overflow), 0);
      chk("idle_data",  int'(out_data), 0);
      chk("idle_wrap",  int'(out_wrap), 0);

      // Single capture, held until read.
      push1(5);
      chk("single_valid", int'(out_valid), 1);
      chk("single_data",  int'(out_data), 5);
      chk("single_wrap",  int'(out_wrap), 0);
      chk("single_level", int'(level), 1);
      cyc(); cyc();
      chk("single_hold", int'(out_data), 5);
      pop_chk("single_rd", 5, 0);
      chk("single_empty", int'(empty), 1);

      // Fill and overflow: six consecutive captures of 0..5.
      capture = 1'b1;
      for (int i = 0; i < 6; i++) begin
         count_in = 4'(i);
         cyc();
         if (i == 3) begin
            chk("fill_full4", int'(full), 1);
            chk("fill_ovf4",  int'(overflow), 0);
         end
         if (i == 4) chk("fill_ovf5", int'(overflow), 1);
      end
      capture = 1'b0;
      chk("fill_level", int'(level), 4);
      for (int i = 0; i < 4; i++) pop_chk("fill_rd", i, 0);
      chk("fill_empty", int'(empty), 1);
      chk("fill_ovf_sticky", int'(overflow), 1);
      clr = 1'b1; cyc(); clr = 1'b0;
      chk("clr_ovf", int'(overflow), 0);

      // Wrap flag: event between captures, then event folded into a push.
      push1(14);
      count_in = 4'hF; cyc();
      count_in = 4'h0; cyc();
      push1(1);
      count_in = 4'h2; cyc();
      push1(3);
      count_in = 4'hF; cyc();
      push1(0);
      chk("wrap_level", int'(level), 4);
      pop_chk("wrap_rd14", 14, 0);
      pop_chk("wrap_rd1", 1, 1);
      pop_chk("wrap_rd3", 3, 0);
      pop_chk("wrap_rd0", 0, 1);
      push1(2);
      pop_chk("wrap_rd2", 2, 0);

      // Full with simultaneous push and pop.
      for (int i = 8; i < 12; i++) push1(i);
      chk("pp_full", int'(full), 1);
      count_in = 4'd12; capture = 1'b1; out_ready = 1'b1;
      cyc();
      capture = 1'b0; out_ready = 1'b0;
      chk("pp_level", int'(level), 4);
      chk("pp_ovf",   int'(overflow), 0);
      for (int i = 9; i < 13; i++) pop_chk("pp_rd", i, 0);

      // Reset mid-operation with level 3 and overflow set.
      for (int i = 0; i < 5; i++) push1(i + 4);
      out_ready = 1'b1; cyc(); out_ready = 1'b0;
      chk("mid_level_pre", int'(level), 3);
      chk("mid_ovf_pre",   int'(overflow), 1);
      #1 reset = 1'b1;
      #1;
      chk("mid_valid", int'(out_valid), 0);
      chk("mid_level", int'(level), 0);
      chk("mid_ovf",   int'(overflow), 0);
      chk("mid_data",  int'(out_data), 0);
      reset = 1'b0;
      cyc();
      push1(7);
      chk("post_level", int'(level), 1);
      pop_chk("post_rd", 7, 0);
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
